// File: rtl/instruction_fetch_unit.sv
// Purpose: front-end fetch stage; owns the PC and one outstanding imem request, and feeds decode from a registered output.
// Latency: one instruction every 2 cycles at best (request cycle, response cycle); output is registered.
// Backpressure: stall_fetch holds the output register; a single skid entry absorbs one in-flight response.
//
// Ports: clk/reset (async, active-high); load/pc_in redirect from the flow controller;
//   stall_fetch from decode; imem_req/imem_addr/imem_ready request channel;
//   imem_rvalid/imem_rdata response channel; fetch_valid/fetch_instruction/fetch_pc
//   to decode; instruction_memory_busy (= !fetch_valid) back to the flow controller.
// Optional: define FETCH_ADDR_ERROR_EN to add fetch_addr_error and trap misaligned redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic        stall_fetch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc,
  output logic        instruction_memory_busy
`ifdef FETCH_ADDR_ERROR_EN
  , output logic      fetch_addr_error
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        fv_q, fv_d;
  logic [31:0] fi_q, fi_d;
  logic [31:0] fpc_q, fpc_d;
  logic        halt;

`ifdef FETCH_ADDR_ERROR_EN
  // halt_q: parked after a misaligned redirect until the next load.
  // err_owed_q: the error pseudo-instruction still has to reach the output register.
  logic halt_q, halt_d;
  logic err_owed_q, err_owed_d;
  logic err_q, err_d;
  assign halt             = halt_q;
  assign fetch_addr_error = err_q;
  // pc_q holds the raw misaligned target while halted; never present it to memory.
  assign imem_addr        = {pc_q[31:2], 2'b00};
`else
  logic unused_pc_in_lsbs;
  assign unused_pc_in_lsbs = ^pc_in[1:0];
  assign halt              = 1'b0;
  assign imem_addr         = pc_q;
`endif

  logic consume, slot_free, accept, resp;

  assign consume   = fv_q & ~stall_fetch;
  assign slot_free = ~fv_q | consume;
  // No new request while a skid entry is parked: keeps at most one response unplaced.
  assign imem_req  = ~reset & (state_q == S_REQ) & ~skid_vld_q & ~halt;
  assign accept    = imem_req & imem_ready;
  assign resp      = (state_q == S_WAIT) & imem_rvalid;

  assign fetch_valid             = fv_q;
  assign fetch_instruction       = fi_q;
  assign fetch_pc                = fpc_q;
  assign instruction_memory_busy = ~fv_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    fv_d         = fv_q;
    fi_d         = fi_q;
    fpc_d        = fpc_q;
`ifdef FETCH_ADDR_ERROR_EN
    halt_d       = halt_q;
    err_owed_d   = err_owed_q;
    err_d        = err_q;
`endif
    if (load) begin
      pc_d       = {pc_in[31:2], 2'b00};
      skid_vld_d = 1'b0;
      // A stalled decode still owns the current output; otherwise it leaves this cycle.
      if (!stall_fetch) fv_d = 1'b0;
      // Any request already accepted must have its response absorbed in S_DROP.
      unique case (state_q)
        S_REQ:   state_d = accept ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
        default: state_d = imem_rvalid ? S_REQ : S_DROP;
      endcase
`ifdef FETCH_ADDR_ERROR_EN
      if (pc_in[1:0] != 2'b00) begin
        pc_d       = pc_in;
        halt_d     = 1'b1;
        err_owed_d = 1'b1;
      end else begin
        halt_d     = 1'b0;
        err_owed_d = 1'b0;
      end
`endif
    end else begin
      if (skid_vld_q && slot_free) begin
        fv_d  = 1'b1;
        fi_d  = skid_instr_q;
        fpc_d = skid_pc_q;
`ifdef FETCH_ADDR_ERROR_EN
        err_d = 1'b0;
`endif
        // A response landing while the skid drains goes behind it to keep order.
        if (resp) begin
          skid_instr_d = imem_rdata;
          skid_pc_d    = pc_q;
        end else begin
          skid_vld_d   = 1'b0;
        end
      end else if (resp) begin
        if (slot_free) begin
          fv_d  = 1'b1;
          fi_d  = imem_rdata;
          fpc_d = pc_q;
`ifdef FETCH_ADDR_ERROR_EN
          err_d = 1'b0;
`endif
        end else begin
          skid_vld_d   = 1'b1;
          skid_instr_d = imem_rdata;
          skid_pc_d    = pc_q;
        end
`ifdef FETCH_ADDR_ERROR_EN
      end else if (err_owed_q && slot_free) begin
        fv_d       = 1'b1;
        fi_d       = 32'h0;
        fpc_d      = pc_q;
        err_d      = 1'b1;
        err_owed_d = 1'b0;
`endif
      end else if (consume) begin
        fv_d = 1'b0;
      end

      unique case (state_q)
        S_REQ:   if (accept) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid) begin
                   pc_d    = pc_q + 32'd4;
                   state_d = S_REQ;
                 end
        default: if (imem_rvalid) state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      fv_q         <= 1'b0;
      fi_q         <= 32'h0;
      fpc_q        <= 32'h0;
`ifdef FETCH_ADDR_ERROR_EN
      halt_q       <= 1'b0;
      err_owed_q   <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      fv_q         <= fv_d;
      fi_q         <= fi_d;
      fpc_q        <= fpc_d;
`ifdef FETCH_ADDR_ERROR_EN
      halt_q       <= halt_d;
      err_owed_q   <= err_owed_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose: directed self-checking bench for instruction_fetch_unit.
// Latency: inputs change 1 time unit after each rising edge; outputs checked at that point.
// Backpressure: stall_fetch and imem_ready/imem_rvalid are driven by hand per step.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] pc_in;
  logic        stall_fetch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        instruction_memory_busy;
`ifdef FETCH_ADDR_ERROR_EN
  logic        fetch_addr_error;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .load                    (load),
    .pc_in                   (pc_in),
    .stall_fetch             (stall_fetch),
    .imem_req                (imem_req),
    .imem_addr               (imem_addr),
    .imem_ready              (imem_ready),
    .imem_rvalid             (imem_rvalid),
    .imem_rdata              (imem_rdata),
    .fetch_valid             (fetch_valid),
    .fetch_instruction       (fetch_instruction),
    .fetch_pc                (fetch_pc),
    .instruction_memory_busy (instruction_memory_busy)
`ifdef FETCH_ADDR_ERROR_EN
    , .fetch_addr_error      (fetch_addr_error)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; pc_in = 32'h0; stall_fetch = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rst_busy", {31'b0, instruction_memory_busy}, 32'd1);
    chk("rst_instr", fetch_instruction, 32'h0);
    chk("rst_pc", fetch_pc, 32'h0);
    reset = 1'b0;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'hBFC0_0000);

    // First fetch
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("wait_noreq", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2402_0001;
    step();
    imem_rvalid = 1'b0;
    chk("f1_valid", {31'b0, fetch_valid}, 32'd1);
    chk("f1_busy", {31'b0, instruction_memory_busy}, 32'd0);
    chk("f1_instr", fetch_instruction, 32'h2402_0001);
    chk("f1_pc", fetch_pc, 32'hBFC0_0000);
    chk("f1_next_req", {31'b0, imem_req}, 32'd1);
    chk("f1_next_addr", imem_addr, 32'hBFC0_0004);

    // Skid buffer: consume first fetch, then stall across A and B
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("f1_consumed", {31'b0, fetch_valid}, 32'd0);
    stall_fetch = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0001;
    step();
    imem_rvalid = 1'b0;
    chk("a_instr", fetch_instruction, 32'hAAAA_0001);
    chk("a_pc", fetch_pc, 32'hBFC0_0004);
    chk("a_next_addr", imem_addr, 32'hBFC0_0008);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hBBBB_0002;
    step();
    imem_rvalid = 1'b0; imem_ready = 1'b1;
    chk("skid_hold_a", fetch_instruction, 32'hAAAA_0001);
    chk("skid_hold_fv", {31'b0, fetch_valid}, 32'd1);
    chk("skid_noreq", {31'b0, imem_req}, 32'd0);
    step();
    chk("skid_hold_a2", fetch_instruction, 32'hAAAA_0001);
    chk("skid_noreq2", {31'b0, imem_req}, 32'd0);
    imem_ready = 1'b0; stall_fetch = 1'b0;
    step();
    chk("b_instr", fetch_instruction, 32'hBBBB_0002);
    chk("b_pc", fetch_pc, 32'hBFC0_0008);
    chk("b_valid", {31'b0, fetch_valid}, 32'd1);
    chk("b_req", {31'b0, imem_req}, 32'd1);
    chk("b_next_addr", imem_addr, 32'hBFC0_000C);

    // Redirect while in S_WAIT; late junk response dropped
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    chk("b_consumed", {31'b0, fetch_valid}, 32'd0);
    load = 1'b1; pc_in = 32'h8000_0180;
    step();
    load = 1'b0;
    chk("drop_noreq", {31'b0, imem_req}, 32'd0);
    step();
    chk("drop_noreq2", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("junk_fv", {31'b0, fetch_valid}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h8000_0180);

    // Redirect coincident with accept, output stalled and retained
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    stall_fetch = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hC0C0_C0C0;
    step();
    imem_rvalid = 1'b0;
    chk("c_instr", fetch_instruction, 32'hC0C0_C0C0);
    chk("c_pc", fetch_pc, 32'h8000_0180);
    load = 1'b1; pc_in = 32'hBFC0_0010; imem_ready = 1'b1;
    step();
    load = 1'b0; imem_ready = 1'b0;
    chk("ld_acc_keep_fv", {31'b0, fetch_valid}, 32'd1);
    chk("ld_acc_keep_c", fetch_instruction, 32'hC0C0_C0C0);
    chk("ld_acc_noreq", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
    step();
    imem_rvalid = 1'b0;
    chk("stale_keep_c", fetch_instruction, 32'hC0C0_C0C0);
    chk("stale_req", {31'b0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'hBFC0_0010);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hD00D_D00D;
    step();
    imem_rvalid = 1'b0;
    chk("d_skid_keep_c", fetch_instruction, 32'hC0C0_C0C0);
    stall_fetch = 1'b0;
    step();
    chk("d_instr", fetch_instruction, 32'hD00D_D00D);
    chk("d_pc", fetch_pc, 32'hBFC0_0010);
    chk("d_next_addr", imem_addr, 32'hBFC0_0014);

    // PC wrap
    load = 1'b1; pc_in = 32'hFFFF_FFFC;
    step();
    load = 1'b0;
    chk("wrap_fv0", {31'b0, fetch_valid}, 32'd0);
    chk("wrap_req", {31'b0, imem_req}, 32'd1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hEEEE_0001;
    step();
    imem_rvalid = 1'b0;
    chk("e_pc", fetch_pc, 32'hFFFF_FFFC);
    chk("e_instr", fetch_instruction, 32'hEEEE_0001);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_0002;
    step();
    imem_rvalid = 1'b0;
    chk("f_pc", fetch_pc, 32'h0000_0000);
    chk("f_instr", fetch_instruction, 32'hFFFF_0002);

    // Misaligned redirect
    load = 1'b1; pc_in = 32'h8000_0003;
    step();
    load = 1'b0;
`ifdef FETCH_ADDR_ERROR_EN
    chk("mis_noreq", {31'b0, imem_req}, 32'd0);
    step();
    chk("mis_fv", {31'b0, fetch_valid}, 32'd1);
    chk("mis_err", {31'b0, fetch_addr_error}, 32'd1);
    chk("mis_pc", fetch_pc, 32'h8000_0003);
    chk("mis_instr", fetch_instruction, 32'h0);
    step();
    chk("mis_idle", {31'b0, imem_req}, 32'd0);
`else
    chk("mis_req", {31'b0, imem_req}, 32'd1);
    chk("mis_addr", imem_addr, 32'h8000_0000);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
`endif

    // Reset mid-transaction with an orphaned response
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    reset = 1'b1;
    #1;
    chk("mid_rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    step();
    reset = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("post_rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("post_rst_addr", imem_addr, 32'hBFC0_0000);
    step();
    chk("post_rst_fv2", {31'b0, fetch_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
